// File: rtl/gcd_rr_arbiter.sv
// Round-robin scheduler sharing one external iterative GCD unit between NREQ requesters.
// Optional zero-operand bypass when GCD_ARB_ZERO_BYPASS_EN is defined.
module gcd_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      result,
    output logic              busy,
    output logic              gcd_start,
    output logic [W-1:0]      gcd_a,
    output logic [W-1:0]      gcd_b,
    input  logic [W-1:0]      gcd_result,
    input  logic              gcd_result_ready
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              wait_first_q;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [W-1:0]      result_q, result_d;
    logic [W-1:0]      gcd_a_q, gcd_a_d;
    logic [W-1:0]      gcd_b_q, gcd_b_d;

    logic [W-1:0]      op_a [NREQ];
    logic [W-1:0]      op_b [NREQ];
    logic              win_valid;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     cand_idx;
    int unsigned       cand;
    logic [W-1:0]      win_a, win_b;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            op_a[i] = req_a[i*W +: W];
            op_b[i] = req_b[i*W +: W];
        end
    end

    // Search starts one past the last winner and wraps, so the last winner ranks lowest.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (!win_valid && req[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign win_a = op_a[win_idx];
    assign win_b = op_b[win_idx];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        ack_d    = '0;
        done_d   = '0;
        result_d = result_q;
        gcd_a_d  = gcd_a_q;
        gcd_b_d  = gcd_b_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    ptr_d          = win_idx;
                    ack_d[win_idx] = 1'b1;
`ifdef GCD_ARB_ZERO_BYPASS_EN
                    if (win_a == '0 || win_b == '0) begin
                        done_d[win_idx] = 1'b1;
                        result_d        = win_a | win_b;
                    end else begin
                        gcd_a_d = win_a;
                        gcd_b_d = win_b;
                        idx_d   = win_idx;
                        state_d = StIssue;
                    end
`else
                    gcd_a_d = win_a;
                    gcd_b_d = win_b;
                    idx_d   = win_idx;
                    state_d = StIssue;
`endif
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                // The unit reads low in its init cycle, so the first WAIT cycle is skipped.
                if (!wait_first_q && gcd_result_ready) begin
                    result_d      = gcd_result;
                    done_d[idx_q] = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= IW'(NREQ - 1);
            idx_q        <= '0;
            wait_first_q <= 1'b0;
            ack_q        <= '0;
            done_q       <= '0;
            result_q     <= '0;
            gcd_a_q      <= '0;
            gcd_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            wait_first_q <= (state_q == StIssue);
            ack_q        <= ack_d;
            done_q       <= done_d;
            result_q     <= result_d;
            gcd_a_q      <= gcd_a_d;
            gcd_b_q      <= gcd_b_d;
        end
    end

    assign ack       = ack_q;
    assign done      = done_q;
    assign result    = result_q;
    assign gcd_a     = gcd_a_q;
    assign gcd_b     = gcd_b_q;
    assign busy      = (state_q != StIdle);
    assign gcd_start = (state_q == StIssue);

endmodule

// File: tb/tb_gcd_rr_arbiter.sv
// Directed self-checking bench for gcd_rr_arbiter with a behavioural subtractive GCD unit.
module tb_gcd_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ-1:0]   ack, done;
    logic [W-1:0]      result, gcd_a, gcd_b, gcd_result;
    logic              busy, gcd_start, gcd_result_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    gcd_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .req_a            (req_a),
        .req_b            (req_b),
        .ack              (ack),
        .done             (done),
        .result           (result),
        .busy             (busy),
        .gcd_start        (gcd_start),
        .gcd_a            (gcd_a),
        .gcd_b            (gcd_b),
        .gcd_result       (gcd_result),
        .gcd_result_ready (gcd_result_ready)
    );

    // GCD unit model: init cycle after start, then one subtraction per cycle; no reset.
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [1:0]   m_st = 2'd0;

    always @(posedge clk) begin
        if (gcd_start) begin
            m_a  <= gcd_a;
            m_b  <= gcd_b;
            m_st <= 2'd1;
        end else if (m_st == 2'd1) begin
            m_st <= 2'd2;
        end else if (m_st == 2'd2) begin
            if (m_a == '0) begin
                m_res <= m_b;
                m_st  <= 2'd0;
            end else if (m_b == '0 || m_a == m_b) begin
                m_res <= m_a;
                m_st  <= 2'd0;
            end else if (m_a > m_b) begin
                m_a <= m_a - m_b;
            end else begin
                m_b <= m_b - m_a;
            end
        end
    end

    assign gcd_result       = m_res;
    assign gcd_result_ready = (m_st == 2'd0);

    always @(posedge clk) if (gcd_start === 1'b1) start_cnt <= start_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        req_a = '0;
        req_b = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int limit, output int cyc);
        for (cyc = 1; cyc <= limit; cyc++) begin
            tick();
            if (ack !== '0) break;
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        for (cyc = 1; cyc <= limit; cyc++) begin
            tick();
            if (done !== '0) break;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ack, done, result} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: ack=%b done=%b result=%0d, want all 0", ack, done, result);
        end
        n_checks++;
        if ({busy, gcd_start, gcd_a, gcd_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_gcd: busy=%b start=%b a=%0d b=%0d, want all 0",
                     busy, gcd_start, gcd_a, gcd_b);
        end
    endtask

    task automatic test_single();
        int cyc;
        int s0;
        s0 = start_cnt;
        set_op(0, 10'd48, 10'd18);
        req = 4'b0001;
        wait_ack(8, cyc);
        n_checks++;
        if (cyc != 1 || ack !== 4'b0001 || gcd_start !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack: cyc=%0d ack=%b start=%b busy=%b, want 1 0001 1 1",
                     cyc, ack, gcd_start, busy);
        end
        req = '0;
        wait_done(200, cyc);
        n_checks++;
        if (done !== 4'b0001 || result !== 10'd6 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: done=%b result=%0d busy=%b, want 0001 6 0",
                     done, result, busy);
        end
        n_checks++;
        if (start_cnt - s0 != 1) begin
            n_fail++;
            $display("FAIL single_starts: got %0d start pulses, want 1", start_cnt - s0);
        end
        tick();
        n_checks++;
        if (done !== '0 || busy !== 1'b0 || result !== 10'd6) begin
            n_fail++;
            $display("FAIL single_after: done=%b busy=%b result=%0d, want 0000 0 6",
                     done, busy, result);
        end
    endtask

    task automatic test_contention();
        int exp_idx [2] = '{0, 2};
        int exp_res [2] = '{4, 7};
        int got   = 0;
        int ndone = 0;
        logic [NREQ-1:0] want;
        do_reset();
        set_op(0, 10'd12, 10'd8);
        set_op(2, 10'd35, 10'd21);
        req = 4'b0101;
        for (int c = 0; c < 400 && ndone < 2; c++) begin
            tick();
            if (ack !== '0) begin
                want = (got < 2) ? (NREQ'(1) << exp_idx[got]) : '0;
                n_checks++;
                if (ack !== want) begin
                    n_fail++;
                    $display("FAIL cont_ack%0d: ack=%b, want %b", got, ack, want);
                end
                req = req & ~ack;
                got++;
            end
            if (done !== '0) begin
                want = NREQ'(1) << exp_idx[ndone];
                n_checks++;
                if (done !== want || result !== W'(exp_res[ndone])) begin
                    n_fail++;
                    $display("FAIL cont_done%0d: done=%b result=%0d, want %b %0d",
                             ndone, done, result, want, exp_res[ndone]);
                end
                ndone++;
            end
        end
        n_checks++;
        if (ndone != 2 || got != 2) begin
            n_fail++;
            $display("FAIL cont_count: acks=%0d dones=%0d, want 2 2", got, ndone);
        end
    endtask

    task automatic test_fairness();
        int got   = 0;
        int ndone = 0;
        int last  = -100;
        int min_gap = 1000;
        bit overlap = 1'b0;
        logic [NREQ-1:0] want;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, W'((i + 1) * 6), W'((i + 1) * 4));
        req = 4'b1111;
        for (int c = 0; c < 1000 && ndone < 8; c++) begin
            tick();
            if (done !== '0 && gcd_start === 1'b1) overlap = 1'b1;
            if (ack !== '0) begin
                want = NREQ'(1) << (got % NREQ);
                n_checks++;
                if (ack !== want) begin
                    n_fail++;
                    $display("FAIL fair_ack%0d: ack=%b, want %b", got, ack, want);
                end
                if (c - last < min_gap) min_gap = c - last;
                last = c;
                got++;
            end
            if (done !== '0) begin
                want = NREQ'(1) << (ndone % NREQ);
                n_checks++;
                if (done !== want || result !== W'(2 * ((ndone % NREQ) + 1))) begin
                    n_fail++;
                    $display("FAIL fair_done%0d: done=%b result=%0d, want %b %0d",
                             ndone, done, result, want, 2 * ((ndone % NREQ) + 1));
                end
                ndone++;
            end
        end
        req = '0;
        n_checks++;
        if (ndone != 8 || got != 8 || min_gap < 4 || overlap) begin
            n_fail++;
            $display("FAIL fair_summary: acks=%0d dones=%0d min_gap=%0d overlap=%0d, want 8 8 >=4 0",
                     got, ndone, min_gap, overlap);
        end
        tick();
    endtask

    task automatic test_operand_hold();
        int cyc;
        set_op(0, 10'd100, 10'd75);
        req = 4'b0001;
        wait_ack(20, cyc);
        req = '0;
        n_checks++;
        if (ack !== 4'b0001 || gcd_a !== 10'd100 || gcd_b !== 10'd75) begin
            n_fail++;
            $display("FAIL hold_grant: ack=%b a=%0d b=%0d, want 0001 100 75", ack, gcd_a, gcd_b);
        end
        tick();
        set_op(0, 10'd77, 10'd33);
        wait_done(200, cyc);
        n_checks++;
        if (done !== 4'b0001 || result !== 10'd25) begin
            n_fail++;
            $display("FAIL hold_result: done=%b result=%0d, want 0001 25", done, result);
        end
        tick();
    endtask

    task automatic test_zero_operand();
        int cyc;
        int s0;
        s0 = start_cnt;
        set_op(1, 10'd0, 10'd25);
        req = 4'b0010;
        wait_ack(20, cyc);
        req = '0;
`ifdef GCD_ARB_ZERO_BYPASS_EN
        n_checks++;
        if (ack !== 4'b0010 || done !== 4'b0010 || result !== 10'd25) begin
            n_fail++;
            $display("FAIL zero_bypass: ack=%b done=%b result=%0d, want 0010 0010 25",
                     ack, done, result);
        end
        tick();
        tick();
        tick();
        n_checks++;
        if (start_cnt != s0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_nostart: starts=%0d busy=%b, want 0 0", start_cnt - s0, busy);
        end
`else
        n_checks++;
        if (ack !== 4'b0010 || gcd_start !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ack: ack=%b start=%b, want 0010 1", ack, gcd_start);
        end
        wait_done(200, cyc);
        n_checks++;
        if (done !== 4'b0010 || result !== 10'd25 || start_cnt - s0 != 1) begin
            n_fail++;
            $display("FAIL zero_done: done=%b result=%0d starts=%0d, want 0010 25 1",
                     done, result, start_cnt - s0);
        end
        tick();
`endif
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        int s0;
        bit seen_done = 1'b0;
        set_op(2, 10'd200, 10'd150);
        req = 4'b0100;
        wait_ack(20, cyc);
        req = '0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || gcd_start !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait: busy=%b start=%b, want 1 0", busy, gcd_start);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({ack, done, result, busy, gcd_start, gcd_a, gcd_b} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: ack=%b done=%b result=%0d busy=%b start=%b a=%0d b=%0d, want 0",
                     ack, done, result, busy, gcd_start, gcd_a, gcd_b);
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done !== '0) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL mid_nodone: done seen=%0d after reset, want 0", seen_done);
        end
        s0 = start_cnt;
        set_op(3, 10'd9, 10'd6);
        req = 4'b1000;
        wait_ack(20, cyc);
        req = '0;
        n_checks++;
        if (ack !== 4'b1000 || gcd_start !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ack3: ack=%b start=%b, want 1000 1", ack, gcd_start);
        end
        wait_done(200, cyc);
        n_checks++;
        if (done !== 4'b1000 || result !== 10'd3 || start_cnt - s0 != 1) begin
            n_fail++;
            $display("FAIL mid_done3: done=%b result=%0d starts=%0d, want 1000 3 1",
                     done, result, start_cnt - s0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        req_a = '0;
        req_b = '0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_operand_hold();
        test_zero_operand();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_rr_arbiter.md
# gcd_rr_arbiter

Round-robin scheduler that shares one iterative GCD unit (start/result_ready handshake, W-bit operands) between NREQ requesters. Each requester presents two operands and a request level. The arbiter grants one requester at a time, issues a single-cycle start to the GCD unit and waits for its completion. It then returns the result with a one-hot done pulse. It sits between the client logic and the GCD instance. The GCD unit has no reset of its own and is instantiated outside this block.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 10, operand/result width; must match the GCD unit
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- req  in  NREQ  request level per requester
- req_a  in  NREQ*W  operand a, requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand b, same packing
- ack  out  NREQ  one-hot, one-cycle pulse: request i accepted, operands latched
- done  out  NREQ  one-hot, one-cycle pulse: result valid for requester i
- result  out  W  GCD result; holds last value until next done
- busy  out  1  high whenever state != IDLE
- gcd_start  out  1  start pulse to GCD unit
- gcd_a, gcd_b  out  W  operands to GCD unit (latched copies)
- gcd_result  in  W  GCD unit result
- gcd_result_ready  in  1  GCD unit idle/ready (low from the cycle after start until finished)

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req bit is high, choose the winner by round robin. The search starts at index ptr+1 mod NREQ.
  - On that edge: latch the winner's a/b into gcd_a/gcd_b, latch its index, set ptr := winner, ack <= onehot(winner), and go to ISSUE.
- ISSUE: gcd_start = 1 combinationally for exactly this cycle; next state is WAIT.
- WAIT: gcd_result_ready is ignored in the first WAIT cycle, because the GCD unit is then in its init state and reads low.
  - When gcd_result_ready = 1: result <= gcd_result, done <= onehot(index), go to IDLE.
- req is sampled only in IDLE. A requester drops req on seeing ack. A req still high when the arbiter is next in IDLE counts as a new request.
- Operands are taken only at grant; later changes to req_a/req_b are ignored.
- Simultaneous requests: exactly one is granted per transaction. A requester waits at most NREQ-1 other transactions.
- Reset (rst_n = 0 at an edge) forces the following, regardless of state:
  - state = IDLE, ptr = NREQ-1 (requester 0 has top priority first), ack = 0, done = 0, result = 0, gcd_a = gcd_b = 0, busy = 0.
  - An aborted transaction produces no done.
  - A still-running GCD unit is not reset. The next gcd_start restarts it, because start has priority inside the unit.
- Widths: no arithmetic beyond the ptr increment, which wraps modulo NREQ. result is W bits, unchanged from gcd_result.

## Timing
- Grant edge E0 ends IDLE cycle T. ack is high and gcd_start is high in cycle T+1.
- The GCD unit is in its init state in T+2.
- If gcd_result_ready is first seen high in cycle T+k (k ≥ 3), done and result are valid in T+k+1. The arbiter is in IDLE in T+k+1 and may grant again on that edge.
- Minimum spacing between two grants is 4 cycles (no bypass).
- done is never asserted in the same cycle as gcd_start.
- ack and done are registered outputs; gcd_start and busy are decoded from state.

## Configuration
- Macro GCD_ARB_ZERO_BYPASS_EN.
- Defined: in IDLE, if the winner's a == 0 or b == 0, the GCD unit is not used.
  - On the grant edge, ack and done both pulse in T+1 with result = a|b (0 when both are zero). State stays IDLE and ptr advances.
  - gcd_start stays low and gcd_a/gcd_b are not updated.
- Undefined: every request goes through ISSUE/WAIT, including zero operands. Results are identical, only latency differs.

## Test plan
- Single request: req0 with (48, 18) → ack[0] one cycle after grant, gcd_start one pulse, done[0] with result = 6, busy low afterwards.
- Contention: req0 (12, 8) and req2 (35, 21) both high from reset → req0 served first (result 4), then req2 (result 7); no other ack/done bits.
- Fairness: all 4 req held high continuously for 8 transactions → grant order 0, 1, 2, 3, 0, 1, 2, 3.
- Operand hold: change req_a/req_b during WAIT → result still reflects the operands latched at grant (e.g., (100, 75) → 25).
- Zero operand: req1 (0, 25).
  - With GCD_ARB_ZERO_BYPASS_EN: ack[1] and done[1] in the same cycle, result = 25, no gcd_start.
  - Without it: result 25 via the GCD unit.
- Reset mid-op: pull rst_n low for 1 cycle during WAIT → no done, all outputs zero. A new req3 (9, 6) then gets result = 3 on a fresh gcd_start.
